mux4_arbiter: RTL
=================

// Module: mux4_arbiter
// PURPOSE
//  Round-robin arbiter sharing the 4:1 operand mux (mux4_1) among four requesters.
//  Grants one requester at a time and drives the mux select S from the owner's index.
//  Sits between the requesting units and the ALU operand path; sel wires to mux4_1.S.
// PARAMETERS
//  MAX_HOLD  8  max consecutive grant cycles before forced rotation (only with MUX4_ARB_TIMEOUT_EN)
//  CNT_W     4  hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk      in   1  single clock, all state updates on rising edge
//  reset    in   1  synchronous, active-high
//  req      in   4  request per source; bit i = mux input i (a,b,c,d)
//  grant    out  4  one-hot registered grant, 0 when idle
//  sel      out  2  binary index of owner, drives mux4_1.S
//  valid    out  1  |grant; the mux output is meaningful
//  preempt  out  1  1-cycle pulse on forced rotation (tied 0 without macro)
// BEHAVIOUR
//  - Reset: one clock and one reset; reset is synchronous and active-high, overrides all
//    else. Next edge: grant=0, sel=2'b00, valid=0, preempt=0, last=3 (so source 0 wins first),
//    hold_cnt=0, state=IDLE.
//  - Reset mid-operation: outputs take reset values at the next edge; the in-flight grant is
//    dropped, no completion.
//  - States: IDLE (no owner), BUSY (owner = sel).
//  - IDLE: if |req, pick the first set bit scanning last+1, last+2, ... (mod 4); at the next
//    edge grant=onehot(pick), sel=pick, state=BUSY. Latency req->grant = 1 cycle.
//  - BUSY, req[owner]=1: hold grant/sel unchanged (no timeout build).
//  - BUSY, req[owner]=0: last<=owner; if other req pending, switch grant directly to
//    next RR pick at the next edge (no idle bubble), stay BUSY; else grant=0, state=IDLE.
//  - sel holds the last owner's index while idle (no glitch on mux S); only valid qualifies it.
//  - Simultaneous new requests resolved strictly by RR order from last+1; owner's own
//    bit is scanned last, so an owner dropping and re-raising loses to any waiting peer.
//  - grant is always one-hot or zero; sel == encode(grant) whenever valid=1.
//  - Requests are level; a requester is not served unless req is high on the decision edge.
// CONFIGURATION
//  MUX4_ARB_TIMEOUT_EN defined:
//   - hold_cnt counts owner cycles from 0, cleared on every new grant.
//   - hold_cnt==MAX_HOLD-1 with another req pending: rotate to next RR pick at the next edge,
//     last<=owner, preempt=1 for that one cycle.
//   - no other req pending: owner keeps grant, hold_cnt saturates at MAX_HOLD-1, no pulse.
//  Not defined: no counter logic, preempt tied 1'b0, owner holds indefinitely.
// STRUCTURE
//  - Shared header mux4_arb_defs.vh: ST_IDLE/ST_BUSY encodings, NREQ=4, SEL_W=2.
//  - Sub-module mux4_rr_pick (combinational): in req[3:0], last[1:0], excl[1:0] ->
//    out found, idx[1:0]; used for both IDLE pick and handover pick.
//  - Top: state reg, last reg, grant/sel regs, optional hold counter; no mux instantiated.
// TESTING
//  1. reset=1 two cycles with req=4'b1111 -> grant=0000, sel=00, valid=0, preempt=0.
//  2. req=0100 from idle -> next edge grant=0100, sel=10, valid=1; drop req -> next edge
//     grant=0000, valid=0, sel stays 10.
//  3. req=1111 after reset, each owner drops its bit for one cycle once granted ->
//     grant sequence 0001,0010,0100,1000,0001 with no idle cycle between.
//  4. owner 0 granted, req=0011, drop bit 0 -> next edge grant=0010, sel=01, valid stays 1.
//  5. grant=0100 held, assert reset one cycle -> grant=0000; then req=1111 -> grant=0001.
//  6. MUX4_ARB_TIMEOUT_EN, MAX_HOLD=4, req=0011 constant -> grant 0001 x4 cycles, 0010 x4,
//     0001 ...; preempt=1 on each switch cycle; req=0001 alone -> no preempt ever.
//  Bench also checks every cycle: grant one-hot or zero, sel==encode(grant) when valid=1.

Source files
------------

// File: rtl/mux4_arbiter_pkg.sv
// rtl/mux4_arbiter_pkg.sv - shared state encodings, widths and helpers for the mux4 arbiter
package mux4_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_arbiter_if.sv
// rtl/mux4_arbiter_if.sv - request/grant bundle between requesters and the mux4 arbiter
interface mux4_arbiter_if;
  import mux4_arbiter_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  grant;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             preempt;

  modport master (output req, input grant, sel, valid, preempt);
  modport slave  (input req, output grant, sel, valid, preempt);

endinterface

// File: rtl/mux4_rr_pick.sv
// rtl/mux4_rr_pick.sv - combinational round-robin pick scanning last+1, last+2, ... (mod 4)
module mux4_rr_pick
  import mux4_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  input  logic [SEL_W-1:0] excl,
  input  logic             excl_en,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [NREQ-1:0]  cand;
  logic [SEL_W-1:0] pos;

  assign cand = req & ~(excl_en ? onehot(excl) : '0);

  always_comb begin
    found = 1'b0;
    idx   = last;
    pos   = last;
    for (int k = 1; k <= NREQ; k++) begin
      pos = last + SEL_W'(k);
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mux4_arbiter.sv
// rtl/mux4_arbiter.sv - round-robin arbiter driving the mux4_1 select; MUX4_ARB_TIMEOUT_EN enables forced rotation
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
)(
  input  logic           clk,
  input  logic           reset,
  mux4_arbiter_if.slave  bus
);

  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("mux4_arbiter: CNT_W too narrow for MAX_HOLD");
  end

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] pick_last;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_excl_en;
  logic             found;
  logic             owner_req;
  logic             timeout;
  logic             rotate;
  logic             new_grant;

  // While busy, scan from the owner and skip it so a waiting peer always wins.
  assign pick_last    = (state_q == ST_BUSY) ? sel_q : last_q;
  assign pick_excl_en = (state_q == ST_BUSY);
  assign owner_req    = bus.req[sel_q];

  mux4_rr_pick u_pick (
    .req     (bus.req),
    .last    (pick_last),
    .excl    (sel_q),
    .excl_en (pick_excl_en),
    .found   (found),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
    rotate    = 1'b0;
    new_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d   = onehot(pick_idx);
          sel_d     = pick_idx;
          state_d   = ST_BUSY;
          new_grant = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!owner_req) begin
          last_d = sel_q;
          if (found) begin
            grant_d   = onehot(pick_idx);
            sel_d     = pick_idx;
            new_grant = 1'b1;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end else if (timeout && found) begin
          last_d    = sel_q;
          grant_d   = onehot(pick_idx);
          sel_d     = pick_idx;
          rotate    = 1'b1;
          new_grant = 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q;
  logic             preempt_q;

  assign timeout = (state_q == ST_BUSY) && (hold_q == CNT_W'(MAX_HOLD - 1));

  // Counter saturates at MAX_HOLD-1 so a late-arriving peer preempts on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= rotate;
      if (new_grant || state_q == ST_IDLE) begin
        hold_q <= '0;
      end else if (!timeout) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  assign bus.preempt = preempt_q;
`else
  assign timeout     = 1'b0;
  assign bus.preempt = 1'b0;
`endif

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.valid = |grant_q;

endmodule
